// File: rtl/led7seg_74hc595_scan_driver.sv
// Serial scan engine for an 8-digit 7-segment module behind two cascaded 74HC595s.
// Each digit shifts {seg, sel} MSB first on sclk/dio, then pulses rclk; frames are sampled at digit 0.
module led7seg_74hc595_scan_driver #(
  parameter int DIG_NUM   = 8,
  parameter int SEG_NUM   = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIG_NUM*SEG_NUM-1:0] dat,
  input  logic                       vld,
  output logic                       sclk,
  output logic                       rclk,
  output logic                       dio,
  output logic                       frame_done
);

  localparam int CHA_WIDTH = DIG_NUM + SEG_NUM;
  localparam int DIG_W     = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
  localparam int BIT_W     = $clog2(CHA_WIDTH);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH
  } state_t;

  logic [DIV_WIDTH-1:0]       r_div;
  state_t                     r_state;
  logic [DIG_W-1:0]           r_dig;
  logic [BIT_W-1:0]           r_bit;
  logic [CHA_WIDTH-1:0]       r_sr;
  logic [DIG_NUM*SEG_NUM-1:0] r_frame;
  logic                       r_sclk;
  logic                       r_rclk;
  logic                       r_dio;
  logic                       r_frame_done;

  logic                       w_tick;
  logic                       w_capture;
  logic                       w_last_bit;
  logic                       w_last_dig;
  logic [SEG_NUM-1:0]         w_seg;
  logic [DIG_NUM-1:0]         w_sel;
  logic [CHA_WIDTH-1:0]       w_word;
  state_t                     w_state_nxt;
  logic [DIG_W-1:0]           w_dig_nxt;
  logic [BIT_W-1:0]           w_bit_nxt;
  logic [CHA_WIDTH-1:0]       w_sr_nxt;
  logic [DIG_NUM*SEG_NUM-1:0] w_frame_nxt;
  logic                       w_sclk_nxt;
  logic                       w_rclk_nxt;
  logic                       w_dio_nxt;
  logic                       w_frame_done_nxt;

  assign w_tick     = &r_div;
  assign w_last_bit = (r_bit == BIT_W'(CHA_WIDTH - 1));
  assign w_last_dig = (r_dig == DIG_W'(DIG_NUM - 1));
  // Digit 0 takes a fresh frame straight from the input on the same edge it is captured.
  assign w_capture  = (r_dig == '0) && vld;

  always_comb begin
    w_sel        = '0;
    w_sel[r_dig] = 1'b1;
    w_seg        = w_capture ? dat[SEG_NUM-1:0] : r_frame[r_dig*SEG_NUM +: SEG_NUM];
    w_word       = {w_seg, w_sel};
  end

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned, which would infer a latch.
    w_state_nxt      = r_state;
    w_dig_nxt        = r_dig;
    w_bit_nxt        = r_bit;
    w_sr_nxt         = r_sr;
    w_frame_nxt      = r_frame;
    w_sclk_nxt       = r_sclk;
    w_rclk_nxt       = r_rclk;
    w_dio_nxt        = r_dio;
    w_frame_done_nxt = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_LOAD: begin
          w_sr_nxt    = w_word;
          w_bit_nxt   = '0;
          if (w_capture) w_frame_nxt = dat;
          w_state_nxt = S_SHIFT_LO;
          w_sclk_nxt  = 1'b0;
          w_rclk_nxt  = 1'b0;
          w_dio_nxt   = w_word[CHA_WIDTH-1];
        end
        S_SHIFT_LO: begin
          w_state_nxt = S_SHIFT_HI;
          w_sclk_nxt  = 1'b1;
        end
        S_SHIFT_HI: begin
          w_sr_nxt   = r_sr << 1;
          w_bit_nxt  = r_bit + BIT_W'(1);
          w_sclk_nxt = 1'b0;
          if (w_last_bit) begin
            w_state_nxt = S_LATCH;
            w_rclk_nxt  = 1'b1;
            w_dio_nxt   = 1'b0;
          end else begin
            // Next bit is presented a full tick before its sclk rise.
            w_state_nxt = S_SHIFT_LO;
            w_dio_nxt   = r_sr[CHA_WIDTH-2];
          end
        end
        S_LATCH: begin
          w_dig_nxt        = w_last_dig ? '0 : r_dig + DIG_W'(1);
          w_frame_done_nxt = w_last_dig;
          w_state_nxt      = S_LOAD;
          w_sclk_nxt       = 1'b0;
          w_rclk_nxt       = 1'b0;
          w_dio_nxt        = 1'b0;
        end
        default: w_state_nxt = S_LOAD;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_state      <= S_LOAD;
      r_dig        <= '0;
      r_bit        <= '0;
      r_sr         <= '0;
      // NOTE: the frame register is plain flops, so it is cleared with everything else to restart blank.
      r_frame      <= '0;
      r_sclk       <= 1'b0;
      r_rclk       <= 1'b0;
      r_dio        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_div        <= r_div + DIV_WIDTH'(1);
      r_state      <= w_state_nxt;
      r_dig        <= w_dig_nxt;
      r_bit        <= w_bit_nxt;
      r_sr         <= w_sr_nxt;
      r_frame      <= w_frame_nxt;
      r_sclk       <= w_sclk_nxt;
      r_rclk       <= w_rclk_nxt;
      r_dio        <= w_dio_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign sclk       = r_sclk;
  assign rclk       = r_rclk;
  assign dio        = r_dio;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led7seg_74hc595_scan_driver.sv
// Bench for the 74HC595 scan driver: slot-arithmetic reference model at DIV_WIDTH=2,
// directed literal checks, and a second instance at default DIV_WIDTH=8 for timing widths.
module tb_led7seg_74hc595_scan_driver;

  localparam int P2          = 4;   // 2^DIV_WIDTH for the fast instance
  localparam int DIG         = 8;
  localparam int SEG         = 8;
  localparam int CHA         = 16;
  localparam int SLOTS       = 34;  // ticks per digit
  localparam int FRAME_SLOTS = 272; // ticks per frame

  localparam logic [63:0] DAT_A = {8'h17, 8'h26, 8'h35, 8'h44, 8'h53, 8'h62, 8'h71, 8'hA5};
  localparam logic [63:0] DAT_B = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0] DAT_C = 64'hFFEE_DDCC_BBAA_9988;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vld, sclk, rclk, dio, fd;
  logic [63:0] dat;
  logic        rst8, vld8, sclk8, rclk8, dio8, fd8;
  logic [63:0] dat8;

  int n_tests = 0;
  int n_fail  = 0;

  led7seg_74hc595_scan_driver #(.DIG_NUM(8), .SEG_NUM(8), .DIV_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .dat(dat), .vld(vld),
    .sclk(sclk), .rclk(rclk), .dio(dio), .frame_done(fd)
  );

  led7seg_74hc595_scan_driver #(.DIG_NUM(8), .SEG_NUM(8), .DIV_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .dat(dat8), .vld(vld8),
    .sclk(sclk8), .rclk(rclk8), .dio(dio8), .frame_done(fd8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: output of the fast instance n edges after reset release,
  // derived from the tick slot number. Returns {sclk, rclk, dio, frame_done}.
  function automatic logic [3:0] model_out(input int n, input logic [63:0] frame);
    int s, k, d, j;
    logic [15:0] word;
    logic [3:0]  o;
    s    = n / P2;
    k    = s % SLOTS;
    d    = (s / SLOTS) % DIG;
    word = {frame[d*SEG +: SEG], 8'(1 << d)};
    o    = 4'b0000;
    if (k >= 1 && k <= 2*CHA) begin
      j    = (k - 1) / 2;
      o[3] = ((k - 1) % 2 == 1);
      o[1] = word[15 - j];
    end
    if (k == 2*CHA + 1) o[2] = 1'b1;
    if (k == 0 && d == 0 && s > 0 && n % P2 == 0) o[0] = 1'b1;
    return o;
  endfunction

  int          m_n = 0;
  logic [63:0] m_frame = '0;
  bit          model_en = 1'b0;
  int          model_prints = 0;
  logic [3:0]  m_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n     <= 0;
      m_frame <= '0;
    end else begin
      if (m_n % P2 == P2 - 1 && (m_n / P2) % FRAME_SLOTS == 0 && vld) m_frame <= dat;
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    if (model_en && !rst) begin
      m_exp = model_out(m_n, m_frame);
      n_tests++;
      if ({sclk, rclk, dio, fd} !== m_exp) begin
        n_fail++;
        if (model_prints < 20) begin
          model_prints++;
          $display("FAIL model n=%0d: sclk/rclk/dio/frame_done got %b, expected %b",
                   m_n, {sclk, rclk, dio, fd}, m_exp);
        end
      end
    end
  end

  // dio must never move within one cycle of an sclk rise on the default instance.
  bit   mon8_en = 1'b0;
  int   c8 = 0;
  int   last_dio_chg = -100;
  int   last_rise = -100;
  logic ps8, pd8;

  always @(negedge clk) begin
    if (mon8_en) begin
      c8++;
      if (sclk8 && !ps8) begin
        n_tests++;
        if (dio8 !== pd8 || c8 - last_dio_chg <= 1) begin
          n_fail++;
          $display("FAIL dio_setup: dio changed %0d cycles before sclk rise, required > 1", c8 - last_dio_chg);
        end
        last_rise = c8;
      end
      if (dio8 !== pd8) begin
        n_tests++;
        if (c8 - last_rise <= 1) begin
          n_fail++;
          $display("FAIL dio_hold: dio changed %0d cycles after sclk rise, required > 1", c8 - last_rise);
        end
        last_dio_chg = c8;
      end
    end
    ps8 = sclk8;
    pd8 = dio8;
  end

  // Collects one digit word from the fast instance: bits on sclk rises up to the rclk rise.
  task automatic capture(output logic [15:0] w, output int rises, output int rwidth,
                         output time t_first, output time t_rclk);
    logic ps, pr;
    w = '0; rises = 0; rwidth = 0; t_first = 0; t_rclk = 0;
    ps = sclk; pr = rclk;
    for (int g = 0; g < 400; g++) begin
      @(negedge clk);
      if (sclk && !ps) begin
        if (rises == 0) t_first = $time;
        w = {w[14:0], dio};
        rises++;
      end
      if (rclk && !pr) begin
        t_rclk = $time;
        break;
      end
      ps = sclk; pr = rclk;
    end
    if (t_rclk == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL capture_timeout: no rclk pulse within 400 cycles");
      return;
    end
    while (rclk && rwidth < 400) begin
      rwidth++;
      @(negedge clk);
    end
  endtask

  task automatic next_word(output logic [15:0] w);
    int r, rw;
    time tf, tr;
    capture(w, r, rw, tf, tr);
  endtask

  task automatic wait_fd(output time t);
    t = 0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (fd) begin
        t = $time;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL frame_done_timeout: no pulse within 3000 cycles");
  endtask

  task automatic run_div2();
    logic [15:0] w;
    int  r, rw;
    time tf, tr, tr_prev, t1, t2, trel;

    capture(w, r, rw, tf, tr);
    check("word0_stream", 32'(w), 32'hA501);
    check("word0_rises", 32'(r), 32'd16);
    check("word0_rclk_width", 32'(rw), 32'd4);
    tr_prev = tr;
    capture(w, r, rw, tf, tr);
    check("word1_stream", 32'(w), 32'h7102);
    check("word_spacing", 32'((tr - tr_prev) / 10), 32'd136);

    wait_fd(t1);
    @(negedge clk);
    check("frame_done_width", 32'(fd), 32'd0);
    wait_fd(t2);
    check("frame_done_period", 32'((t2 - t1) / 10), 32'd1088);

    // New data arrives while digit 3 is being scanned.
    for (int d = 0; d < 3; d++) next_word(w);
    check("frame_d2_before_change", 32'(w), 32'h6204);
    dat = DAT_B;
    next_word(w);
    check("mid_frame_d3_old", 32'(w), 32'h5308);
    next_word(w);
    check("mid_frame_d4_old", 32'(w), 32'h4410);
    for (int d = 5; d < 8; d++) next_word(w);
    check("mid_frame_d7_old", 32'(w), 32'h1780);
    next_word(w);
    check("next_frame_d0_new", 32'(w), 32'h7801);
    next_word(w);
    check("next_frame_d1_new", 32'(w), 32'h6902);

    // Invalid data through the next boundary: the held frame persists.
    vld = 1'b0;
    dat = DAT_C;
    next_word(w);
    check("vld0_d2_old", 32'(w), 32'h5A04);
    for (int d = 3; d < 8; d++) next_word(w);
    next_word(w);
    check("vld0_next_d0_held", 32'(w), 32'h7801);
    for (int d = 1; d < 8; d++) next_word(w);
    check("vld0_next_d7_held", 32'(w), 32'h0F80);

    // Asynchronous reset in the middle of SHIFT_HI.
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (sclk) break;
    end
    check("pre_reset_in_shift_hi", 32'(sclk), 32'd1);
    #1 rst = 1'b1;
    #1 check("async_reset_outputs", 32'({sclk, rclk, dio, fd}), 32'd0);
    @(posedge clk);
    trel = $time;
    #1 rst = 1'b0;
    capture(w, r, rw, tf, tr);
    check("reset_first_sclk_cycles", 32'((tf - trel - 5) / 10), 32'd8);
    check("reset_frame_cleared_d0", 32'(w), 32'h0001);
    next_word(w);
    check("reset_frame_cleared_d1", 32'(w), 32'h0002);
  endtask

  task automatic run_div8();
    int  hw, lw, rises;
    time t1, t2;
    logic ps;
    hw = 0; lw = 0; rises = 0; t1 = 0; t2 = 0;
    mon8_en = 1'b1;
    for (int g = 0; g < 20000; g++) begin
      @(negedge clk);
      if (sclk8) break;
    end
    while (sclk8 && hw < 2000) begin
      hw++;
      @(negedge clk);
    end
    while (!sclk8 && lw < 2000) begin
      lw++;
      @(negedge clk);
    end
    check("div8_sclk_high", 32'(hw), 32'd256);
    check("div8_sclk_low", 32'(lw), 32'd256);

    for (int g = 0; g < 20000; g++) begin
      @(negedge clk);
      if (rclk8) begin
        t1 = $time;
        break;
      end
    end
    ps = sclk8;
    for (int g = 0; g < 20000; g++) begin
      @(negedge clk);
      if (sclk8 && !ps) rises++;
      ps = sclk8;
      if (rclk8 && rises > 0) begin
        t2 = $time;
        break;
      end
    end
    check("div8_rises_per_digit", 32'(rises), 32'd16);
    check("div8_digit_period", 32'((t2 - t1) / 10), 32'd8704);
    mon8_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; vld = 1'b0; dat = '0;
    rst8 = 1'b0; vld8 = 1'b0; dat8 = '0;
    #2 rst = 1'b1; rst8 = 1'b1;
    #1 check("reset_outputs", 32'({sclk, rclk, dio, fd}), 32'd0);
    check("reset_outputs_div8", 32'({sclk8, rclk8, dio8, fd8}), 32'd0);
    dat = DAT_A; vld = 1'b1;
    dat8 = DAT_A; vld8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst8 = 1'b0;
    model_en = 1'b1;
    fork
      run_div2();
      run_div8();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
